load_store_unit: RTL and testbench

//  Parametrised load/store unit of the RV32 core. Replaces flat address decode with a full LSU:
//  - computes the effective address (EA) and checks alignment;
//  - drives a req/gnt/rvalid data-memory port and byte enables;
//  - returns sign/zero-extended load data, or an error code, to the core.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_lane_align.sv | 56 +++++
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32 load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } lsu_err_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Legal funct3 encodings: stores take B/H/W only, loads add the unsigned variants.
  function automatic logic op_is_legal(input logic is_store, input logic [2:0] funct3);
    logic ok;
    ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    if (!is_store) begin
      ok = ok || (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-enable generation, store-data lane replication and load extract/extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the read word.
  always_comb begin
    byte_sel = rdata[7:0];
    case (ea_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = ea_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Size decode: funct3[1:0] is the access size, funct3[2] selects zero-extension.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = '0;
    ld_data   = '0;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << ea_lo;
        wdata_rep = {4{wdata[7:0]}};
        ld_data   = funct3[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        be        = 4'b0011 << ea_lo;
        wdata_rep = {2{wdata[15:0]}};
        ld_data   = funct3[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        ld_data   = rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: EA + alignment check, req/gnt/rvalid memory port, extended load data.
// Latency: store 2 cycles, load 3 cycles (gnt first REQ cycle, rvalid next), errors 1 cycle.
// Backpressure: one op in flight; req_ready only in IDLE, memory stalls held by mem_gnt/mem_rvalid.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [11:0]       req_offset,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  // Counter wide enough to hold TIMEOUT_CYC-1 even when TIMEOUT_CYC is 0 or 1.
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  lsu_state_e        state;
  logic              op_store_q;
  logic [2:0]        op_f3_q;
  logic [1:0]        ea_lo_q;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W-1:0] ea;
  logic              legal;
  logic              misalign;
  logic              expire;
  logic [2:0]        al_f3;
  logic [1:0]        al_ea;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_ld;

  // Effective address wraps modulo 2^ADDR_W; wrap is not an error.
  assign ea = req_base + {{(ADDR_W-12){req_offset[11]}}, req_offset};

  // Legality and alignment of the op currently presented on the request port.
  always_comb begin
    legal    = op_is_legal(req_op[3], req_op[2:0]);
    misalign = 1'b0;
    if (req_op[1:0] == 2'b01) misalign = ea[0];
    if (req_op[1:0] == 2'b10) misalign = (ea[1:0] != 2'b00);
  end

  // Expiry fires in the TIMEOUT_CYC-th cycle spent in REQ+WAIT (count starts at 0 on entry).
  assign expire = (TIMEOUT_CYC != 0) && (cnt == TO_LAST);

  // In IDLE the aligner sees the incoming op; afterwards it sees the latched op for load extract.
  assign al_f3 = (state == IDLE) ? req_op[2:0] : op_f3_q;
  assign al_ea = (state == IDLE) ? ea[1:0]     : ea_lo_q;

  lsu_lane_align u_align (
    .funct3    (al_f3),
    .ea_lo     (al_ea),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .ld_data   (al_ld)
  );

  // Ready is forced low during reset so the core never sees a stale accept.
  assign req_ready = (state == IDLE) && !rst;

  // Main FSM with registered memory-port and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_store_q <= 1'b0;
      op_f3_q    <= 3'b000;
      ea_lo_q    <= 2'b00;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= ERR_NONE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_store_q <= req_op[3];
            op_f3_q    <= req_op[2:0];
            ea_lo_q    <= ea[1:0];
            if (!legal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= ERR_ILLEGAL;
            end else if (misalign) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= ERR_MISALIGN;
            end else begin
              state     <= REQ;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_op[3];
              mem_addr  <= {ea[ADDR_W-1:2], 2'b00};
              mem_be    <= al_be;
              mem_wdata <= req_op[3] ? al_wdata : 32'd0;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (op_store_q) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= ERR_NONE;
            end else begin
              state <= WAIT;
            end
          end else if (expire) begin
            mem_req   <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= ERR_TIMEOUT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_rvalid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= al_ld;
            rsp_err   <= ERR_NONE;
          end else if (expire) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= ERR_TIMEOUT;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= ERR_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a cycle-level memory responder.
// Latency: n/a.
// Backpressure: grant/rvalid delays chosen per vector.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_base;
  logic [11:0] req_offset;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // Results captured by run_op.
  int          r_lat;
  int          r_req_cyc;
  logic [31:0] r_rdata;
  logic [1:0]  r_err;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic        r_we;
  logic [31:0] r_wdata;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Presents one op at a negedge and plays memory: gnt on REQ cycle gnt_dly (-1 = never),
  // rvalid rv_dly cycles after gnt (-1 = never). Latency counts negedges after presentation.
  task automatic run_op(input logic [3:0] op, input logic [31:0] base, input logic [11:0] off,
                        input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rd);
    int  gnt_at;
    bit  granted;
    bit  done;
    check("ready_before_op", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_base   = base;
    req_offset = off;
    req_wdata  = wd;
    granted    = 1'b0;
    done       = 1'b0;
    gnt_at     = 0;
    r_lat      = -1;
    r_req_cyc  = 0;
    r_rdata    = 'x;
    r_err      = 'x;
    r_addr     = '0;
    r_be       = '0;
    r_we       = 1'b0;
    r_wdata    = '0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (rsp_valid) begin
        r_lat   = cyc;
        r_rdata = rsp_rdata;
        r_err   = rsp_err;
        done    = 1'b1;
      end else if (mem_req) begin
        if (r_req_cyc == 0) begin
          r_addr  = mem_addr;
          r_be    = mem_be;
          r_we    = mem_we;
          r_wdata = mem_wdata;
        end
        if (gnt_dly >= 0 && r_req_cyc == gnt_dly) begin
          mem_gnt = 1'b1;
          granted = 1'b1;
          gnt_at  = cyc;
        end
        r_req_cyc++;
      end else if (granted && rv_dly >= 0 && cyc == gnt_at + rv_dly) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
      end
    end
    check("op_completed", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_base   = '0;
    req_offset = '0;
    req_wdata  = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // Reset state: all outputs low, ready included.
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1. SW base 0x100, off -4.
    run_op(4'b1010, 32'h100, 12'hFFC, 32'hDEADBEEF, 0, -1, 32'd0);
    check("sw_addr", r_addr, 32'h0000_00FC);
    check("sw_be", {28'd0, r_be}, 32'hF);
    check("sw_we", {31'd0, r_we}, 32'd1);
    check("sw_wdata", r_wdata, 32'hDEADBEEF);
    check("sw_lat", r_lat, 32'd2);
    check("sw_err", {30'd0, r_err}, 32'd0);
    check("sw_rdata", r_rdata, 32'd0);

    // 2. LB / LBU at EA 0x203.
    run_op(4'b0000, 32'h200, 12'h003, 32'd0, 0, 1, 32'h80FF_FFFF);
    check("lb_rdata", r_rdata, 32'hFFFF_FF80);
    check("lb_lat", r_lat, 32'd3);
    check("lb_addr", r_addr, 32'h0000_0200);
    check("lb_be", {28'd0, r_be}, 32'h8);
    check("lb_we", {31'd0, r_we}, 32'd0);
    run_op(4'b0100, 32'h200, 12'h003, 32'd0, 0, 1, 32'h80FF_FFFF);
    check("lbu_rdata", r_rdata, 32'h0000_0080);
    check("lbu_err", {30'd0, r_err}, 32'd0);

    // 3. SH at 0x102, then misaligned LH at 0x101.
    run_op(4'b1001, 32'h100, 12'h002, 32'h1234ABCD, 0, -1, 32'd0);
    check("sh_be", {28'd0, r_be}, 32'hC);
    check("sh_wdata", r_wdata, 32'hABCDABCD);
    check("sh_addr", r_addr, 32'h0000_0100);
    run_op(4'b0001, 32'h100, 12'h001, 32'd0, 0, 1, 32'd0);
    check("lh_mis_err", {30'd0, r_err}, 32'd1);
    check("lh_mis_noreq", r_req_cyc, 32'd0);
    check("lh_mis_lat", r_lat, 32'd1);

    // Halfword extraction both lanes, SB lane 1, LW with address wrap.
    run_op(4'b0001, 32'h200, 12'h002, 32'd0, 0, 1, 32'h8001_1234);
    check("lh_hi_sext", r_rdata, 32'hFFFF_8001);
    run_op(4'b0101, 32'h200, 12'h000, 32'd0, 0, 1, 32'h8001_9234);
    check("lhu_lo_zext", r_rdata, 32'h0000_9234);
    run_op(4'b1000, 32'h100, 12'h001, 32'h0000_005A, 0, -1, 32'd0);
    check("sb_be", {28'd0, r_be}, 32'h2);
    check("sb_wdata", r_wdata, 32'h5A5A5A5A);
    run_op(4'b0010, 32'hFFFF_FFFC, 12'h008, 32'd0, 2, 3, 32'hCAFE_F00D);
    check("lw_wrap_addr", r_addr, 32'h0000_0004);
    check("lw_wrap_rdata", r_rdata, 32'hCAFE_F00D);
    check("lw_slow_lat", r_lat, 32'd7);

    // 4. LW with gnt withheld -> timeout after 16 REQ cycles; then a late rvalid.
    run_op(4'b0010, 32'h300, 12'h000, 32'd0, -1, -1, 32'd0);
    check("to_err", {30'd0, r_err}, 32'd2);
    check("to_req_cycles", r_req_cyc, 32'd16);
    check("to_lat", r_lat, 32'd17);
    check("to_mem_req_low", {31'd0, mem_req}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rvalid_ignored", {31'd0, rsp_valid}, 32'd0);
    check("late_rvalid_ready", {31'd0, req_ready}, 32'd1);
    // Grant in the expiry cycle wins over the timeout.
    run_op(4'b1010, 32'h300, 12'h000, 32'h5555_AAAA, 15, -1, 32'd0);
    check("gnt_at_expiry_err", {30'd0, r_err}, 32'd0);
    check("gnt_at_expiry_lat", r_lat, 32'd17);

    // 5. Illegal ops.
    run_op(4'b0011, 32'h100, 12'h000, 32'd0, 0, 1, 32'd0);
    check("ill_ld_err", {30'd0, r_err}, 32'd3);
    check("ill_ld_noreq", r_req_cyc, 32'd0);
    run_op(4'b1100, 32'h100, 12'h000, 32'd0, 0, 1, 32'd0);
    check("ill_st_err", {30'd0, r_err}, 32'd3);
    check("ill_st_noreq", r_req_cyc, 32'd0);

    // 6. Reset while in WAIT.
    req_valid  = 1'b1;
    req_op     = 4'b0010;
    req_base   = 32'h400;
    req_offset = 12'h000;
    @(negedge clk);
    req_valid = 1'b0;
    check("w_mem_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h2222_2222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    run_op(4'b0010, 32'h400, 12'h004, 32'd0, 0, 1, 32'h0BAD_C0DE);
    check("post_rst_lw_rdata", r_rdata, 32'h0BAD_C0DE);
    check("post_rst_lw_addr", r_addr, 32'h0000_0404);
    check("post_rst_lw_err", {30'd0, r_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
